// File: rtl/judge3_pkg.sv
// Purpose : shared types and constants for the three-judge vote controller.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: state encoding (enum plus legacy localparam constants), judge bit
//           indices into the 3-bit vote vectors, and a 3-bit popcount helper.
package judge3_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DECIDE  = 2'd2,
        RESULT  = 2'd3
    } state_e;

    // Plain-vector views of the state encoding.
    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_COLLECT = COLLECT;
    localparam logic [1:0] ST_DECIDE  = DECIDE;
    localparam logic [1:0] ST_RESULT  = RESULT;

    // Bit positions of each judge in vote_valid / vote_val / voted / votes.
    localparam int J_A = 2;
    localparam int J_B = 1;
    localparam int J_C = 0;

    // Number of set bits in a 3-bit vector (0..3).
    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/judge3.sv
// Purpose : combinational 2-of-3 majority voter.
// Latency : 0 cycles (pure combinational).
// Backpressure: none.
// Ports   : a, b, c - individual votes (1 = yes); out - 1 when at least two are 1.
module judge3 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic out
);

    assign out = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/judge3_ctrl.sv
// Purpose : vote-session controller for a three-judge panel; latches each judge's
//           first vote in a window that closes on full attendance or timeout,
//           then presents a registered majority decision.
// Latency : final vote accepted at edge N -> DECIDE after N, result_valid after N+1.
// Backpressure: result is held in RESULT until result_ack; votes are only acked
//           (vote_ack) for the first strobe per judge while collecting.
// Ports   : clk, rst_n (sync, active-low), start, vote_valid[2:0], vote_val[2:0],
//           vote_ack[2:0], busy, result_valid, result, yes_cnt[1:0], timed_out,
//           result_ack. Bit order of the vote vectors is a=2, b=1, c=0.
// Config  : define JUDGE3_CHIEF_VETO_EN to make judge a a chief whose absent or
//           "no" vote forces result=0 (yes_cnt is unaffected).
module judge3_ctrl
    import judge3_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100,
    parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] vote_valid,
    input  logic [2:0] vote_val,
    output logic [2:0] vote_ack,
    output logic       busy,
    output logic       result_valid,
    output logic       result,
    output logic [1:0] yes_cnt,
    output logic       timed_out,
    input  logic       result_ack
);

    logic [1:0]       state_q,     state_d;
    logic [2:0]       voted_q,     voted_d;
    logic [2:0]       votes_q,     votes_d;
    logic [CNT_W-1:0] timer_q,     timer_d;
    logic             result_q,    result_d;
    logic [1:0]       yes_cnt_q,   yes_cnt_d;
    logic             timed_out_q, timed_out_d;

    logic [2:0]       accept;
    logic             majority;
    logic             decision;
    logic             window_full;
    logic             window_expired;

    // Majority over the latched votes; absent judges hold 0 and so count as "no".
    judge3 u_voter (
        .a   (votes_q[J_A]),
        .b   (votes_q[J_B]),
        .c   (votes_q[J_C]),
        .out (majority)
    );

`ifdef JUDGE3_CHIEF_VETO_EN
    assign decision = majority & votes_q[J_A];
`else
    assign decision = majority;
`endif

    // A strobe is accepted only for judges that have not yet voted this session.
    assign accept   = vote_valid & ~voted_q & {3{state_q == ST_COLLECT}};
    assign vote_ack = accept;

    // Completion includes this cycle's accepts, so a simultaneous timeout
    // still reports a complete panel (timed_out derives from voted later).
    assign window_full    = ((voted_q | accept) == 3'b111);
    assign window_expired = (timer_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d     = state_q;
        voted_d     = voted_q;
        votes_d     = votes_q;
        timer_d     = timer_q;
        result_d    = result_q;
        yes_cnt_d   = yes_cnt_q;
        timed_out_d = timed_out_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_COLLECT;
                    voted_d     = 3'b000;
                    votes_d     = 3'b000;
                    timer_d     = '0;
                    result_d    = 1'b0;
                    yes_cnt_d   = 2'd0;
                    timed_out_d = 1'b0;
                end
            end
            ST_COLLECT: begin
                voted_d = voted_q | accept;
                votes_d = (votes_q & ~accept) | (vote_val & accept);
                // Timer stops advancing once the window closes, so it never
                // exceeds TIMEOUT_CYC and fits in CNT_W bits.
                timer_d = timer_q + CNT_W'(1);
                if (window_full || window_expired) begin
                    state_d = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                result_d    = decision;
                yes_cnt_d   = popcount3(votes_q);
                timed_out_d = (voted_q != 3'b111);
                state_d     = ST_RESULT;
            end
            ST_RESULT: begin
                if (result_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            voted_q     <= 3'b000;
            votes_q     <= 3'b000;
            timer_q     <= '0;
            result_q    <= 1'b0;
            yes_cnt_q   <= 2'd0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            voted_q     <= voted_d;
            votes_q     <= votes_d;
            timer_q     <= timer_d;
            result_q    <= result_d;
            yes_cnt_q   <= yes_cnt_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign result_valid = (state_q == ST_RESULT);
    assign result       = result_q;
    assign yes_cnt      = yes_cnt_q;
    assign timed_out    = timed_out_q;

endmodule

// File: tb/tb_judge3_ctrl.sv
// Purpose : self-checking bench for judge3_ctrl with a session-level reference
//           model, a per-cycle output compare, directed scenarios and random traffic.
// Latency : n/a.
// Backpressure: n/a.
module tb_judge3_ctrl;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] vote_valid = 3'b000;
    logic [2:0] vote_val = 3'b000;
    logic [2:0] vote_ack;
    logic       busy;
    logic       result_valid;
    logic       result;
    logic [1:0] yes_cnt;
    logic       timed_out;
    logic       result_ack = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    judge3_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .vote_valid   (vote_valid),
        .vote_val     (vote_val),
        .vote_ack     (vote_ack),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .yes_cnt      (yes_cnt),
        .timed_out    (timed_out),
        .result_ack   (result_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (session view) ----------------
    bit       m_live = 0;     // model valid once a reset has been applied
    bit       m_open = 0;     // voting window open
    bit       m_pend = 0;     // window closed, decision not yet published
    bit       m_rv   = 0;     // decision published and awaiting ack
    int       m_cycles = 0;   // window cycles elapsed
    bit [2:0] m_voted = 0;
    bit [2:0] m_votes = 0;
    int       m_res = 0, m_yes = 0, m_to = 0;

    always @(posedge clk) begin
        bit [2:0] acc;
        int yes;
        if (!rst_n) begin
            m_live = 1; m_open = 0; m_pend = 0; m_rv = 0; m_cycles = 0;
            m_voted = 0; m_votes = 0; m_res = 0; m_yes = 0; m_to = 0;
        end else if (m_open) begin
            acc = vote_valid & ~m_voted;
            for (int i = 0; i < 3; i++)
                if (acc[i]) m_votes[i] = vote_val[i];
            m_voted = m_voted | acc;
            m_cycles++;
            if (m_voted == 3'b111 || m_cycles == TO) begin
                m_open = 0;
                m_pend = 1;
            end
        end else if (m_pend) begin
            yes = int'(m_votes[0]) + int'(m_votes[1]) + int'(m_votes[2]);
            m_yes = yes;
`ifdef JUDGE3_CHIEF_VETO_EN
            m_res = (yes >= 2 && m_votes[2]) ? 1 : 0;
`else
            m_res = (yes >= 2) ? 1 : 0;
`endif
            m_to   = (m_voted != 3'b111) ? 1 : 0;
            m_pend = 0;
            m_rv   = 1;
        end else if (m_rv) begin
            if (result_ack) m_rv = 0;
        end else if (start) begin
            m_open = 1; m_cycles = 0; m_voted = 0; m_votes = 0;
            m_res = 0; m_yes = 0; m_to = 0;
        end
    end

    // Outputs compared on every falling edge once the model is live.
    always @(negedge clk) begin
        if (m_live) begin
            chk("vote_ack", int'(vote_ack), m_open ? int'(vote_valid & ~m_voted) : 0);
            chk("busy", int'(busy), int'(m_open | m_pend | m_rv));
            chk("result_valid", int'(result_valid), int'(m_rv));
            chk("result", int'(result), m_res);
            chk("yes_cnt", int'(yes_cnt), m_yes);
            chk("timed_out", int'(timed_out), m_to);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rv(output int n);
        n = 0;
        while (!result_valid && n < 40) begin
            step();
            n++;
        end
        if (!result_valid) chk("result_valid_timeout", 0, 1);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_ack();
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
    endtask

    task automatic vote(input logic [2:0] vv, input logic [2:0] val);
        vote_valid = vv;
        vote_val   = val;
        step();
        vote_valid = 3'b000;
        vote_val   = 3'b000;
    endtask

    int n;

    initial begin
        // Reset state
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_result_valid", int'(result_valid), 0);
        chk("rst_yes_cnt", int'(yes_cnt), 0);

        // 1: all three at once, a=1 b=1 c=0
        do_start();
        vote_valid = 3'b111;
        vote_val   = 3'b110;
        #1;
        chk("t1_ack", int'(vote_ack), 7);
        step();
        vote_valid = 3'b000;
        vote_val   = 3'b000;
        step();
        chk("t1_rv", int'(result_valid), 1);
        chk("t1_result", int'(result), 1);
        chk("t1_yes", int'(yes_cnt), 2);
        chk("t1_to", int'(timed_out), 0);
        do_ack();
        chk("t1_idle", int'(busy), 0);

        // 2: staggered a=0, b=0, c=1
        do_start();
        vote(3'b100, 3'b000);
        step();
        vote(3'b010, 3'b000);
        step();
        vote(3'b001, 3'b001);
        wait_rv(n);
        chk("t2_latency", n, 1);
        chk("t2_result", int'(result), 0);
        chk("t2_yes", int'(yes_cnt), 1);
        chk("t2_to", int'(timed_out), 0);
        do_ack();
        chk("t2_idle", int'(busy), 0);

        // 3: timeout with c absent
        do_start();
        vote(3'b100, 3'b100);
        vote(3'b010, 3'b010);
        wait_rv(n);
        chk("t3_edges", n + 2, TO + 1);
        chk("t3_result", int'(result), 1);
        chk("t3_yes", int'(yes_cnt), 2);
        chk("t3_to", int'(timed_out), 1);
        do_ack();

        // 4: a re-strobes; first vote stands
        do_start();
        vote(3'b100, 3'b100);
        vote_valid = 3'b100;
        vote_val   = 3'b000;
        #1;
        chk("t4_reack", int'(vote_ack), 0);
        step();
        vote(3'b010, 3'b000);
        vote(3'b001, 3'b001);
        wait_rv(n);
        chk("t4_result", int'(result), 1);
        chk("t4_yes", int'(yes_cnt), 2);
        do_ack();

        // 5: reset mid-window
        do_start();
        vote(3'b100, 3'b100);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t5_busy", int'(busy), 0);
        chk("t5_result", int'(result), 0);
        chk("t5_yes", int'(yes_cnt), 0);
        do_start();
        vote(3'b111, 3'b111);
        wait_rv(n);
        chk("t5_result2", int'(result), 1);
        chk("t5_yes2", int'(yes_cnt), 3);
        do_ack();

        // 6: chief says no
        do_start();
        vote(3'b111, 3'b011);
        wait_rv(n);
`ifdef JUDGE3_CHIEF_VETO_EN
        chk("t6_result", int'(result), 0);
`else
        chk("t6_result", int'(result), 1);
`endif
        chk("t6_yes", int'(yes_cnt), 2);
        do_ack();

        // Random traffic, checked by the per-cycle compare
        for (int k = 0; k < 2500; k++) begin
            start = ($urandom_range(0, 3) == 0);
            for (int j = 0; j < 3; j++)
                vote_valid[j] = ($urandom_range(0, 5) == 0);
            vote_val   = 3'($urandom);
            result_ack = ($urandom_range(0, 2) == 0);
            rst_n      = ($urandom_range(0, 149) != 0);
            step();
        end
        start = 1'b0; vote_valid = 3'b000; vote_val = 3'b000;
        result_ack = 1'b0; rst_n = 1'b1;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
